// File: rtl/vec_simd_unit.sv
// rtl/vec_simd_unit.sv - SIMD vector unit: VRF, lane-parallel add/sub, lane-serial load/store
module vec_simd_unit #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int NVREG  = 4,
    parameter int ADDR_W = 8,
    localparam int RIDX_W = $clog2(NVREG),
    localparam int VEC_W  = LANES * LANE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              sat,
    input  logic [RIDX_W-1:0] vd,
    input  logic [RIDX_W-1:0] vs,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [LANES-1:0]  zmask,
    output logic [ADDR_W-1:0] next_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANE_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [LANE_W-1:0] mem_rdata,
    input  logic [RIDX_W-1:0] dbg_sel,
    output logic [VEC_W-1:0]  dbg_data
);

    localparam int CNT_W = $clog2(LANES + 1);

    localparam logic [1:0] OP_VADD   = 2'b00;
    localparam logic [1:0] OP_VLOAD  = 2'b10;
    localparam logic [1:0] OP_VSTORE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_LD,
        S_ST,
        S_WB
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              sat_q, sat_d;
    logic [RIDX_W-1:0] vd_q, vd_d;
    logic [RIDX_W-1:0] vs_q, vs_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [VEC_W-1:0]  x1_q, x1_d;
    logic [VEC_W-1:0]  x2_q, x2_d;
    logic [VEC_W-1:0]  t_q, t_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LANES-1:0]  zmask_q, zmask_d;
    logic              vrf_we;

    logic [VEC_W-1:0]  vrf_q [NVREG];

    logic [VEC_W-1:0]  exec_res;
    logic [LANES-1:0]  t_zero;

    // Per-lane arithmetic: one extra bit catches carry (add) or borrow (sub)
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W:0]   sum;
        logic [LANE_W:0]   diff;
        logic [LANE_W-1:0] add_res;
        logic [LANE_W-1:0] sub_res;

        assign sum     = {1'b0, x1_q[g*LANE_W +: LANE_W]} + {1'b0, x2_q[g*LANE_W +: LANE_W]};
        assign diff    = {1'b0, x1_q[g*LANE_W +: LANE_W]} - {1'b0, x2_q[g*LANE_W +: LANE_W]};
        assign add_res = (sat_q && sum[LANE_W])  ? {LANE_W{1'b1}} : sum[LANE_W-1:0];
        assign sub_res = (sat_q && diff[LANE_W]) ? {LANE_W{1'b0}} : diff[LANE_W-1:0];

        assign exec_res[g*LANE_W +: LANE_W] = (op_q == OP_VADD) ? add_res : sub_res;
        assign t_zero[g] = (t_q[g*LANE_W +: LANE_W] == {LANE_W{1'b0}});
    end

    // Next-state and datapath register updates for the control FSM
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sat_d       = sat_q;
        vd_d        = vd_q;
        vs_d        = vs_q;
        base_d      = base_q;
        next_addr_d = next_addr_q;
        k_d         = k_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        t_d         = t_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        zmask_d     = zmask_q;
        vrf_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d        = op;
                    sat_d       = sat;
                    vd_d        = vd;
                    vs_d        = vs;
                    base_d      = base_addr;
                    next_addr_d = base_addr + ADDR_W'(LANES);
                    k_d         = '0;
                    busy_d      = 1'b1;
                    state_d     = (op == OP_VLOAD) ? S_LD : S_FETCH;
                end
            end
            S_FETCH: begin
                x1_d    = vrf_q[vd_q];
                x2_d    = vrf_q[vs_q];
                k_d     = '0;
                state_d = (op_q == OP_VSTORE) ? S_ST : S_EXEC;
            end
            S_EXEC: begin
                t_d     = exec_res;
                state_d = S_WB;
            end
            S_LD: begin
                // Read data lags the address by one cycle, so counter k lands in lane k-1
                for (int j = 0; j < LANES; j++) begin
                    if (k_q == CNT_W'(j + 1)) begin
                        t_d[j*LANE_W +: LANE_W] = mem_rdata;
                    end
                end
                if (k_q == CNT_W'(LANES)) begin
                    state_d = S_WB;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_ST: begin
                if (k_q == CNT_W'(LANES - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WB: begin
                vrf_we  = 1'b1;
                zmask_d = t_zero;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            sat_q       <= 1'b0;
            vd_q        <= '0;
            vs_q        <= '0;
            base_q      <= '0;
            next_addr_q <= '0;
            k_q         <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            t_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zmask_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sat_q       <= sat_d;
            vd_q        <= vd_d;
            vs_q        <= vs_d;
            base_q      <= base_d;
            next_addr_q <= next_addr_d;
            k_q         <= k_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            t_q         <= t_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zmask_q     <= zmask_d;
        end
    end

    // Vector register file, written only from T during write-back
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NVREG; r++) begin
                vrf_q[r] <= '0;
            end
        end else if (vrf_we) begin
            vrf_q[vd_q] <= t_q;
        end
    end

    // Memory port decode: address/data follow the lane counter in LD and ST only
    always_comb begin
        mem_wren  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == S_ST) begin
            mem_wren = 1'b1;
            mem_addr = base_q + ADDR_W'(k_q);
            for (int j = 0; j < LANES; j++) begin
                if (k_q == CNT_W'(j)) begin
                    mem_wdata = x1_q[j*LANE_W +: LANE_W];
                end
            end
        end else if (state_q == S_LD && k_q < CNT_W'(LANES)) begin
            mem_addr = base_q + ADDR_W'(k_q);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign zmask     = zmask_q;
    assign next_addr = next_addr_q;
    assign dbg_data  = vrf_q[dbg_sel];

endmodule

// File: tb/tb_vec_simd_unit.sv
// tb/tb_vec_simd_unit.sv - self-checking bench for vec_simd_unit
module tb_vec_simd_unit;

    localparam logic [1:0] VADD   = 2'b00;
    localparam logic [1:0] VSUB   = 2'b01;
    localparam logic [1:0] VLOAD  = 2'b10;
    localparam logic [1:0] VSTORE = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        sat;
    logic [1:0]  vd;
    logic [1:0]  vs;
    logic [7:0]  base_addr;
    logic        busy;
    logic        done;
    logic [3:0]  zmask;
    logic [7:0]  next_addr;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic [7:0]  mem_rdata;
    logic [1:0]  dbg_sel;
    logic [31:0] dbg_data;

    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  mem [256];

    int          checks = 0;
    int          errors = 0;

    logic [31:0] ref_vrf [4];
    logic [3:0]  ref_zmask;
    logic [7:0]  ref_mem [256];

    always #5 clock = ~clock;

    vec_simd_unit dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .sat       (sat),
        .vd        (vd),
        .vs        (vs),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .zmask     (zmask),
        .next_addr (next_addr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_rdata (mem_rdata),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    // Single-port byte memory with one-cycle read latency plus a bench preload port
    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wren) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input bit is_sub, input bit s);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            int x, y, r;
            x = int'((a >> (8 * i)) & 32'hFF);
            y = int'((b >> (8 * i)) & 32'hFF);
            r = is_sub ? x - y : x + y;
            if (s) begin
                if (r < 0)   r = 0;
                if (r > 255) r = 255;
            end
            res = res | ((32'(r) & 32'hFF) << (8 * i));
        end
        return res;
    endfunction

    function automatic logic [3:0] ref_z(input logic [31:0] v);
        logic [3:0] z;
        for (int i = 0; i < 4; i++) z[i] = (((v >> (8 * i)) & 32'hFF) == 32'h0);
        return z;
    endfunction

    task automatic preload_byte(input logic [7:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    task automatic preload4(input logic [7:0] b, input logic [31:0] w);
        for (int i = 0; i < 4; i++) preload_byte(8'(b + 8'(i)), 8'(w >> (8 * i)));
    endtask

    // Issue one operation, check per-cycle memory traffic and the committed result
    task automatic run_op(input logic [1:0] o, input logic s, input logic [1:0] d,
                          input logic [1:0] v, input logic [7:0] b, input bit pulse);
        logic [31:0] exp_vec;
        logic [3:0]  exp_z;
        int          lat;
        bit          seen;
        exp_vec = '0;
        case (o)
            VADD:    exp_vec = ref_alu(ref_vrf[d], ref_vrf[v], 1'b0, s);
            VSUB:    exp_vec = ref_alu(ref_vrf[d], ref_vrf[v], 1'b1, s);
            VLOAD:   for (int i = 0; i < 4; i++)
                         exp_vec = exp_vec | (32'(ref_mem[8'(b + 8'(i))]) << (8 * i));
            default: exp_vec = ref_vrf[d];
        endcase
        exp_z = (o == VSTORE) ? ref_zmask : ref_z(exp_vec);
        lat   = (o == VLOAD) ? 6 : (o == VSTORE) ? 5 : 3;

        start = 1'b1; op = o; sat = s; vd = d; vs = v; base_addr = b; dbg_sel = d;
        @(posedge clock); #1;
        start = 1'b0; op = 2'($urandom); sat = 1'($urandom);
        vd = 2'($urandom); vs = 2'($urandom); base_addr = 8'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (o == VLOAD) chk("ld_addr0", 32'(mem_addr), 32'(b));

        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(posedge clock); #1;
            if (pulse && n == 2) begin start = 1'b1; op = VLOAD; end
            if (pulse && n == 3) start = 1'b0;
            if (o == VLOAD && n <= 3)
                chk("ld_addr", 32'(mem_addr), 32'(8'(b + 8'(n))));
            if (o == VSTORE && n <= 4) begin
                chk("st_wren", 32'(mem_wren), 32'd1);
                chk("st_addr", 32'(mem_addr), 32'(8'(b + 8'(n - 1))));
                chk("st_wdata", 32'(mem_wdata), (ref_vrf[d] >> (8 * (n - 1))) & 32'hFF);
            end
            if (done) begin
                seen = 1'b1;
                chk("latency", 32'(n), 32'(lat));
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("wren_at_done", 32'(mem_wren), 32'd0);
                chk("result", dbg_data, exp_vec);
                chk("zmask", 32'(zmask), 32'(exp_z));
                chk("next_addr", 32'(next_addr), 32'(8'(b + 8'd4)));
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);

        if (o == VSTORE) begin
            for (int i = 0; i < 4; i++) ref_mem[8'(b + 8'(i))] = 8'(exp_vec >> (8 * i));
        end else begin
            ref_vrf[d] = exp_vec;
            ref_zmask  = exp_z;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; sat = 1'b0; vd = '0; vs = '0;
        base_addr = '0; dbg_sel = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        for (int r = 0; r < 4; r++) ref_vrf[r] = '0;
        ref_zmask = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_zmask", 32'(zmask), 32'd0);
        chk("rst_next_addr", 32'(next_addr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r); #1;
            chk("rst_vrf", dbg_data, 32'd0);
        end
        reset = 1'b0;
        @(posedge clock); #1;

        preload4(8'h10, 32'h04030201);
        preload4(8'h20, 32'hFF0180FF);
        preload4(8'h30, 32'hDDCCBBAA);
        preload4(8'h40, 32'h05010101);

        run_op(VLOAD, 1'b0, 2'd1, 2'd0, 8'h10, 1'b0);
        chk("vload_const", dbg_data, 32'h04030201);
        run_op(VLOAD, 1'b0, 2'd2, 2'd0, 8'h20, 1'b0);
        run_op(VLOAD, 1'b0, 2'd3, 2'd0, 8'h30, 1'b0);

        run_op(VADD, 1'b0, 2'd1, 2'd2, 8'h00, 1'b0);
        chk("vadd_wrap_const", dbg_data, 32'h03048200);
        chk("vadd_wrap_zmask", 32'(zmask), 32'h1);
        run_op(VLOAD, 1'b0, 2'd1, 2'd0, 8'h10, 1'b0);
        run_op(VADD, 1'b1, 2'd1, 2'd2, 8'h00, 1'b0);
        chk("vadd_sat_const", dbg_data, 32'hFF0482FF);

        run_op(VLOAD, 1'b0, 2'd1, 2'd0, 8'h10, 1'b0);
        run_op(VLOAD, 1'b0, 2'd2, 2'd0, 8'h40, 1'b0);
        run_op(VSUB, 1'b1, 2'd1, 2'd2, 8'h00, 1'b0);
        chk("vsub_sat_const", dbg_data, 32'h00020100);
        chk("vsub_sat_zmask", 32'(zmask), 32'h9);
        run_op(VLOAD, 1'b0, 2'd1, 2'd0, 8'h10, 1'b0);
        run_op(VSUB, 1'b0, 2'd1, 2'd2, 8'h00, 1'b0);
        chk("vsub_wrap_const", dbg_data, 32'hFF020100);

        run_op(VADD, 1'b1, 2'd2, 2'd2, 8'h00, 1'b0);

        preload_byte(8'h00, 8'h11);
        preload_byte(8'h01, 8'h22);
        run_op(VSTORE, 1'b0, 2'd3, 2'd0, 8'hFE, 1'b1);
        chk("st_next_addr_const", 32'(next_addr), 32'h02);
        @(posedge clock); #1;
        chk("st_no_restart", 32'(busy), 32'd0);
        chk("st_mem_fe", 32'(mem[8'hFE]), 32'hAA);
        chk("st_mem_ff", 32'(mem[8'hFF]), 32'hBB);
        chk("st_mem_00", 32'(mem[8'h00]), 32'hCC);
        chk("st_mem_01", 32'(mem[8'h01]), 32'hDD);

        for (int it = 0; it < 40; it++) begin
            logic [1:0] ro;
            logic [7:0] rb;
            ro = 2'($urandom);
            rb = 8'($urandom);
            if (ro == VLOAD) preload4(rb, $urandom);
            run_op(ro, 1'($urandom), 2'($urandom), 2'($urandom), rb, ro == VSTORE);
        end
        for (int a = 0; a < 256; a++) chk("mem_image", 32'(mem[a]), 32'(ref_mem[a]));

        preload4(8'h30, 32'hDDCCBBAA);
        run_op(VLOAD, 1'b0, 2'd3, 2'd0, 8'h30, 1'b0);
        preload_byte(8'h00, 8'h11);
        preload_byte(8'h01, 8'h22);
        start = 1'b1; op = VSTORE; sat = 1'b0; vd = 2'd3; vs = 2'd0; base_addr = 8'hFE;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        chk("abort_wr0", 32'(mem_wren), 32'd1);
        @(posedge clock); #1;
        chk("abort_wr1", 32'(mem_wren), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_wren", 32'(mem_wren), 32'd0);
        for (int n = 0; n < 6; n++) begin
            @(posedge clock); #1;
            chk("abort_quiet_wren", 32'(mem_wren), 32'd0);
            chk("abort_quiet_done", 32'(done), 32'd0);
        end
        chk("abort_mem_fe", 32'(mem[8'hFE]), 32'hAA);
        chk("abort_mem_ff", 32'(mem[8'hFF]), 32'hBB);
        chk("abort_mem_00", 32'(mem[8'h00]), 32'h11);
        chk("abort_mem_01", 32'(mem[8'h01]), 32'h22);
        dbg_sel = 2'd3; #1;
        chk("abort_vrf3", dbg_data, 32'd0);
        chk("abort_zmask", 32'(zmask), 32'd0);
        chk("abort_next_addr", 32'(next_addr), 32'd0);
        ref_mem[8'hFE] = 8'hAA;
        ref_mem[8'hFF] = 8'hBB;
        for (int r = 0; r < 4; r++) ref_vrf[r] = '0;
        ref_zmask = '0;

        run_op(VLOAD, 1'b0, 2'd0, 2'd0, 8'hFE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_simd_unit.md
# vec_simd_unit

Parametrised SIMD vector execution unit: the next generation of the processor's fixed 4×8-bit vector datapath (VRF, X1/X2 operand latches, T lane registers). It owns a vector register file of NVREG registers, each LANES×LANE_W bits. Under a start/busy/done handshake from the control FSM it executes lane-parallel add/subtract, with wrapping or unsigned-saturating arithmetic, and lane-serial vector load/store against the single-port byte memory. It returns a post-incremented address for the scalar register update.

## Interface
- LANES, 4, number of lanes (≥2)
- LANE_W, 8, bits per lane; also the memory data width
- NVREG, 4, vector registers (power of two); RIDX_W = log2(NVREG)
- ADDR_W, 8, memory address width
- Clock and reset: one clock; reset is synchronous and active-high.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears FSM, VRF, all registers and outputs
- start  in  1  request; sampled only in IDLE
- op  in  2  00 VADD, 01 VSUB, 10 VLOAD, 11 VSTORE
- sat  in  1  1 = unsigned saturating add/sub, 0 = wrap
- vd  in  RIDX_W  destination (and first source, and store source)
- vs  in  RIDX_W  second source (VADD/VSUB)
- base_addr  in  ADDR_W  lane-0 memory address (VLOAD/VSTORE)
- busy  out  1  high from the accept edge until done
- done  out  1  one-cycle pulse: the result is committed
- zmask  out  LANES  per-lane result==0 flags, updated at VADD/VSUB/VLOAD commit
- next_addr  out  ADDR_W  (base_addr + LANES) mod 2^ADDR_W, registered at accept
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LANE_W  store data
- mem_wren  out  1  memory write enable
- mem_rdata  in  LANE_W  memory read data, valid the cycle after mem_addr
- dbg_sel  in  RIDX_W  debug read select
- dbg_data  out  LANES*LANE_W  combinational VRF[dbg_sel]; lane k = bits [k*LANE_W +: LANE_W]

## Operation
- States: IDLE, FETCH, EXEC, LD, ST, WB.
- IDLE + start=1: latch op, sat, vd, vs, base_addr, and next_addr; clear lane counter k; busy<=1. Next state: FETCH for VADD/VSUB/VSTORE, LD for VLOAD.
- start while busy is ignored. Inputs other than mem_rdata and dbg_sel are ignored after accept.
- FETCH: X1<=VRF[vd], X2<=VRF[vs]. Next state: EXEC (VADD/VSUB) or ST (VSTORE).
- EXEC: T lane k <= f(X1 lane k, X2 lane k) for all lanes in parallel. Next state: WB.
  - VADD wrap: sum mod 2^LANE_W. VADD sat: sum clamped to 2^LANE_W−1.
  - VSUB is X1−X2. Wrap: mod 2^LANE_W. Sat: clamped to 0.
- LD: drive mem_addr = base+k for k = 0..LANES−1, one per cycle. Capture mem_rdata into T lane k−1 on the following edge. After LANES+1 cycles, next state: WB.
- ST: for k = 0..LANES−1, one per cycle: mem_wren=1, mem_addr=base+k, mem_wdata=X1 lane k. Then next state: IDLE with done=1.
- WB: VRF[vd]<=T; zmask<=per-lane (T==0). Next state: IDLE with done=1, busy<=0.
- Address arithmetic is mod 2^ADDR_W: base+k wraps, e.g. 0xFF+1 = 0x00.
- vd==vs is legal; both operands read the pre-operation value.
- In IDLE: mem_wren=0, mem_addr=0, mem_wdata=0.

## Timing
- Reset values: busy=0, done=0, zmask=0, next_addr=0, mem_addr=0, mem_wdata=0, mem_wren=0. All VRF, X and T registers are 0.
- Accept edge is E0.
- VADD/VSUB: VRF written at E3; done high in cycle E3–E4; dbg_data shows the result from E3.
- VLOAD: addresses presented in cycles E0–E1 … E(LANES−1)–E(LANES). Last capture at E(LANES+1), VRF write at E(LANES+2); done follows E(LANES+2). This is 6 edges for LANES=4.
- VSTORE: writes occur in cycles E1+k–E2+k; done follows E(LANES+1).
- A new start is accepted in the done cycle (back-to-back, no bubble).
- Reset asserted mid-operation: at the next edge the unit returns to IDLE and is fully cleared. mem_wren is 0 from that edge, so no partial write occurs afterwards; done does not pulse.

## Test plan
- Reset: assert reset 2 cycles -> busy=done=mem_wren=0, zmask=0, dbg_data=0 for dbg_sel=0..3.
- VLOAD: vd=1, base=0x10, mem[0x10..0x13]=01,02,03,04 -> mem_addr 10,11,12,13 on consecutive cycles; done one cycle after E6; VRF1=0x04030201; next_addr=0x14; zmask=0000.
- VADD: VRF1=0x04030201, VRF2=0xFF0180FF, vd=1, vs=2 -> done after E3.
  - sat=0: VRF1=0x03048200, zmask=0001.
  - sat=1: VRF1=0xFF0482FF, zmask=0000.
- VSUB: VRF1=0x04030201, VRF2=0x05010101, vd=1, vs=2 -> sat=1 gives 0x00020100 (zmask=1001); sat=0 gives 0xFF020100.
- VSTORE with wrap: VRF3=0xDDCCBBAA, vd=3, base=0xFE -> writes AA@FE, BB@FF, CC@00, DD@01; next_addr=0x02. Pulsing start during the store has no effect.
- Reset mid-VSTORE after 2 writes -> no further mem_wren; mem[00],mem[01] unchanged; busy=0; VRF3=0.
